// File: rtl/instr_encoder_if.sv
// Descriptor handshake and instruction-memory write bus of the instruction encoder.
// master drives descriptors, slave is the encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 256
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              start_i;
    logic [ADDR_W-1:0] base_i;
    logic              valid_i;
    logic              ready_o;
    logic              last_i;
    logic [3:0]        op_sel_i;
    logic [4:0]        rs_i;
    logic [4:0]        rt_i;
    logic [4:0]        rd_i;
    logic [4:0]        shamt_i;
    logic [5:0]        funct_i;
    logic [15:0]       imm_i;
    logic [25:0]       target_i;
    logic              im_we_o;
    logic [ADDR_W-1:0] im_addr_o;
    logic [31:0]       im_data_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output start_i, base_i, valid_i, last_i, op_sel_i, rs_i, rt_i, rd_i,
               shamt_i, funct_i, imm_i, target_i,
        input  ready_o, im_we_o, im_addr_o, im_data_o, busy_o, done_o, err_o, count_o
    );

    modport slave (
        input  start_i, base_i, valid_i, last_i, op_sel_i, rs_i, rt_i, rd_i,
               shamt_i, funct_i, imm_i, target_i,
        output ready_o, im_we_o, im_addr_o, im_data_o, busy_o, done_o, err_o, count_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs field-level descriptors into MIPS
// words and writes them sequentially into instruction memory from a base address.
module instr_encoder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input logic            clk_i,
    input logic            rst_i,
    instr_encoder_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BGT   = 6'b000111;
    localparam logic [5:0] OPC_BNEZ  = 6'b000101;
    localparam logic [5:0] OPC_BGEZ  = 6'b000001;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t            state_q, state_n;
    logic              ready_q, ready_n;
    logic              we_q, we_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic [ADDR_W-1:0] ptr_q, ptr_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [31:0]       data_q, data_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;

    logic              enc_ok_c;
    logic [31:0]       enc_word_c;
    logic              accept_c;

    // Field packing of the presented descriptor; enc_ok_c is low for unmapped kinds.
    always_comb begin
        enc_ok_c   = 1'b1;
        enc_word_c = '0;
        case (bus.op_sel_i)
            4'd0:    enc_word_c = {OPC_RTYPE, bus.rs_i, bus.rt_i, bus.rd_i, bus.shamt_i, bus.funct_i};
            4'd1:    enc_word_c = {OPC_LW,   bus.rs_i, bus.rt_i, bus.imm_i};
            4'd2:    enc_word_c = {OPC_SW,   bus.rs_i, bus.rt_i, bus.imm_i};
            4'd3:    enc_word_c = {OPC_BEQ,  bus.rs_i, bus.rt_i, bus.imm_i};
            4'd4:    enc_word_c = {OPC_ADDI, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd5:    enc_word_c = {OPC_J,    bus.target_i};
            4'd6:    enc_word_c = {OPC_ORI,  bus.rs_i, bus.rt_i, bus.imm_i};
            4'd7:    enc_word_c = {OPC_JAL,  bus.target_i};
            4'd8:    enc_word_c = {OPC_BGT,  bus.rs_i, bus.rt_i, bus.imm_i};
            4'd9:    enc_word_c = {OPC_BNEZ, bus.rs_i, 5'b00000, bus.imm_i};
            4'd10:   enc_word_c = {OPC_BGEZ, bus.rs_i, 5'b00001, bus.imm_i};
            4'd11:   enc_word_c = {OPC_LUI,  5'b00000, bus.rt_i, bus.imm_i};
            default: enc_ok_c   = 1'b0;
        endcase
    end

    assign accept_c = bus.valid_i && ready_q;

    // Next state and next registered outputs.
    always_comb begin
        state_n = state_q;
        we_n    = 1'b0;
        addr_n  = addr_q;
        data_n  = data_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        err_n   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_n = S_LOAD;
                    ptr_n   = bus.base_i;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept_c) begin
                    if (enc_ok_c) begin
                        we_n   = 1'b1;
                        addr_n = ptr_q;
                        data_n = enc_word_c;
                        ptr_n  = ptr_q + ADDR_W'(4);
                        cnt_n  = cnt_q + CNT_W'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                    if (bus.last_i) begin
                        state_n = S_DONE;
                    end else if (cnt_n == CNT_W'(DEPTH)) begin
                        // Session capacity reached without a last marker.
                        state_n = S_DONE;
                        err_n   = 1'b1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        ready_n = (state_n == S_LOAD) && (cnt_n < CNT_W'(DEPTH));
        busy_n  = (state_n != S_IDLE);
        done_n  = (state_n == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            ready_q <= ready_n;
            we_q    <= we_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
            ptr_q   <= ptr_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            cnt_q   <= cnt_n;
        end
    end

    assign bus.ready_o   = ready_q;
    assign bus.im_we_o   = we_q;
    assign bus.im_addr_o = addr_q;
    assign bus.im_data_o = data_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.count_o   = cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// sessions scored against a field-level encoding model.
module tb_instr_encoder;
    localparam int unsigned AW  = 32;
    localparam int unsigned DP  = 256;
    localparam int unsigned SDP = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(AW), .DEPTH(DP))  b();
    instr_encoder_if #(.ADDR_W(AW), .DEPTH(SDP)) s();

    instr_encoder #(.ADDR_W(AW), .DEPTH(DP))  u_dut   (.clk_i(clk), .rst_i(rst_n), .bus(b));
    instr_encoder #(.ADDR_W(AW), .DEPTH(SDP)) u_small (.clk_i(clk), .rst_i(rst_n), .bus(s));

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
    } desc_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] wq[$];
    int          wcyc[$];
    int          dcyc[$];
    logic [63:0] sq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor for both instances.
    always @(negedge clk) begin
        if (b.im_we_o === 1'b1) begin
            wq.push_back({b.im_addr_o, b.im_data_o});
            wcyc.push_back(cyc);
        end
        if (b.done_o === 1'b1) dcyc.push_back(cyc);
        if (s.im_we_o === 1'b1) sq.push_back({s.im_addr_o, s.im_data_o});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Reference encoding: {ok, word} built directly from the opcode map.
    function automatic logic [32:0] ref_encode(input desc_t d);
        case (d.op)
            4'd0:    return {1'b1, 6'd0,  d.rs, d.rt, d.rd, d.sh, d.fn};
            4'd1:    return {1'b1, 6'd35, d.rs, d.rt, d.imm};
            4'd2:    return {1'b1, 6'd43, d.rs, d.rt, d.imm};
            4'd3:    return {1'b1, 6'd4,  d.rs, d.rt, d.imm};
            4'd4:    return {1'b1, 6'd8,  d.rs, d.rt, d.imm};
            4'd5:    return {1'b1, 6'd2,  d.tgt};
            4'd6:    return {1'b1, 6'd13, d.rs, d.rt, d.imm};
            4'd7:    return {1'b1, 6'd3,  d.tgt};
            4'd8:    return {1'b1, 6'd7,  d.rs, d.rt, d.imm};
            4'd9:    return {1'b1, 6'd5,  d.rs, 5'd0, d.imm};
            4'd10:   return {1'b1, 6'd1,  d.rs, 5'd1, d.imm};
            4'd11:   return {1'b1, 6'd15, 5'd0, d.rt, d.imm};
            default: return 33'd0;
        endcase
    endfunction

    function automatic desc_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                                 input logic [25:0] tgt, input logic last);
        desc_t d;
        d.op = op; d.rs = rs; d.rt = rt; d.rd = rd; d.sh = 5'd0; d.fn = fn;
        d.imm = imm; d.tgt = tgt; d.last = last;
        return d;
    endfunction

    function automatic desc_t rand_desc(input logic last);
        desc_t d;
        d.op   = 4'($urandom_range(0, 15));
        d.rs   = 5'($urandom);
        d.rt   = 5'($urandom);
        d.rd   = 5'($urandom);
        d.sh   = 5'($urandom);
        d.fn   = 6'($urandom);
        d.imm  = 16'($urandom);
        d.tgt  = 26'($urandom);
        d.last = last;
        return d;
    endfunction

    task automatic idle_inputs();
        b.start_i = 1'b0; b.base_i = '0; b.valid_i = 1'b0; b.last_i = 1'b0; b.op_sel_i = '0;
        b.rs_i = '0; b.rt_i = '0; b.rd_i = '0; b.shamt_i = '0; b.funct_i = '0; b.imm_i = '0; b.target_i = '0;
        s.start_i = 1'b0; s.base_i = '0; s.valid_i = 1'b0; s.last_i = 1'b0; s.op_sel_i = '0;
        s.rs_i = '0; s.rt_i = '0; s.rd_i = '0; s.shamt_i = '0; s.funct_i = '0; s.imm_i = '0; s.target_i = '0;
    endtask

    task automatic clear_mon();
        wq.delete(); wcyc.delete(); dcyc.delete(); sq.delete();
    endtask

    // Called at a negedge while IDLE; returns at the first negedge of LOAD.
    task automatic start_sess(input logic [AW-1:0] base);
        b.start_i = 1'b1;
        b.base_i  = base;
        @(negedge clk);
        b.start_i = 1'b0;
        b.base_i  = AW'($urandom);
    endtask

    // Present a descriptor and hold it until accepted; returns at the negedge after the accept.
    task automatic send(input desc_t d);
        bit acc = 1'b0;
        b.valid_i = 1'b1; b.last_i = d.last; b.op_sel_i = d.op; b.rs_i = d.rs; b.rt_i = d.rt;
        b.rd_i = d.rd; b.shamt_i = d.sh; b.funct_i = d.fn; b.imm_i = d.imm; b.target_i = d.tgt;
        for (int i = 0; i < 64; i++) begin
            if (b.ready_o === 1'b1) acc = 1'b1;
            @(negedge clk);
            if (acc) break;
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_accept: accepted=%0b required=1 (op=%0d)", acc, d.op);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b.ready_o, b.im_we_o, b.im_addr_o, b.im_data_o, b.busy_o, b.done_o, b.err_o, b.count_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%h data=%h busy=%b done=%b err=%b count=%0d required all 0",
                     b.ready_o, b.im_we_o, b.im_addr_o, b.im_data_o, b.busy_o, b.done_o, b.err_o, b.count_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b.valid_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (b.ready_o !== 1'b0 || b.busy_o !== 1'b0 || wq.size() != 0) begin
            failures++;
            $display("FAIL idle_ignores_valid: ready=%b busy=%b writes=%0d required 0 0 0",
                     b.ready_o, b.busy_o, wq.size());
        end
        b.valid_i = 1'b0;
    endtask

    task automatic test_addi();
        clear_mon();
        start_sess(32'h100);
        checks++;
        if (b.ready_o !== 1'b1 || b.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL load_entry: ready=%b busy=%b required 1 1", b.ready_o, b.busy_o);
        end
        send(mk(4'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1));
        b.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 1 || dcyc.size() != 1) begin
            failures++;
            $display("FAIL addi_counts: writes=%0d dones=%0d required 1 1", wq.size(), dcyc.size());
        end else begin
            checks++;
            if (wq[0] !== {32'h100, 32'h20080005}) begin
                failures++;
                $display("FAIL addi_word: got %h required %h", wq[0], {32'h100, 32'h20080005});
            end
            checks++;
            if (dcyc[0] != wcyc[0]) begin
                failures++;
                $display("FAIL addi_done_align: done cycle %0d required %0d", dcyc[0], wcyc[0]);
            end
        end
        checks++;
        if (b.count_o !== 9'd1 || b.err_o !== 1'b0 || b.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL addi_status: count=%0d err=%b busy=%b required 1 0 0", b.count_o, b.err_o, b.busy_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp [4];
        exp[0] = {32'h100, 32'h01095020};
        exp[1] = {32'h104, 32'h3C011234};
        exp[2] = {32'h108, 32'h05010003};
        exp[3] = {32'h10C, 32'h08000010};
        clear_mon();
        start_sess(32'h100);
        send(mk(4'd0,  5'd8, 5'd9, 5'd10, 6'h20, 16'd0,      26'd0,     1'b0));
        send(mk(4'd11, 5'd0, 5'd1, 5'd0,  6'd0,  16'h1234,   26'd0,     1'b0));
        send(mk(4'd10, 5'd8, 5'd0, 5'd0,  6'd0,  16'd3,      26'd0,     1'b0));
        send(mk(4'd5,  5'd0, 5'd0, 5'd0,  6'd0,  16'd0,      26'h10,    1'b1));
        b.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: writes=%0d required 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wq[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL b2b_word%0d: got %h required %h", i, wq[i], exp[i]);
                end
                checks++;
                if (wcyc[i] != wcyc[0] + i) begin
                    failures++;
                    $display("FAIL b2b_gap%0d: cycle %0d required %0d", i, wcyc[i], wcyc[0] + i);
                end
            end
        end
        checks++;
        if (b.count_o !== 9'd4) begin
            failures++;
            $display("FAIL b2b_count_o: got %0d required 4", b.count_o);
        end
    endtask

    task automatic test_invalid();
        clear_mon();
        start_sess(32'h200);
        send(mk(4'd4,  5'd1, 5'd2, 5'd0, 6'd0, 16'h0011, 26'd0, 1'b0));
        send(mk(4'd13, 5'd3, 5'd4, 5'd5, 6'd0, 16'h0022, 26'd0, 1'b0));
        send(mk(4'd4,  5'd6, 5'd7, 5'd0, 6'd0, 16'h0033, 26'd0, 1'b1));
        b.valid_i = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (wq.size() != 2) begin
            failures++;
            $display("FAIL inv_writes: writes=%0d required 2", wq.size());
        end else begin
            checks++;
            if (wq[0] !== {32'h200, 32'h20220011} || wq[1] !== {32'h204, 32'h20C70033}) begin
                failures++;
                $display("FAIL inv_words: got %h %h required %h %h", wq[0], wq[1],
                         {32'h200, 32'h20220011}, {32'h204, 32'h20C70033});
            end
        end
        checks++;
        if (b.err_o !== 1'b1 || b.count_o !== 9'd2) begin
            failures++;
            $display("FAIL inv_sticky: err=%b count=%0d required 1 2", b.err_o, b.count_o);
        end
        clear_mon();
        start_sess(32'h300);
        checks++;
        if (b.err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_clear_on_start: err=%b required 0", b.err_o);
        end
        send(mk(4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1));
        b.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 0 || dcyc.size() != 1 || b.err_o !== 1'b1 || b.busy_o !== 1'b0 || b.count_o !== 9'd0) begin
            failures++;
            $display("FAIL inv_last: writes=%0d dones=%0d err=%b busy=%b count=%0d required 0 1 1 0 0",
                     wq.size(), dcyc.size(), b.err_o, b.busy_o, b.count_o);
        end
    endtask

    task automatic test_overflow();
        int acc_n = 0;
        bit acc;
        logic [32:0] enc;
        clear_mon();
        s.start_i = 1'b1; s.base_i = 32'h40;
        @(negedge clk);
        s.start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s.valid_i = 1'b1; s.last_i = 1'b0; s.op_sel_i = 4'd4; s.rs_i = 5'd0;
            s.rt_i = 5'(k + 1); s.imm_i = 16'(k + 1);
            acc = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (s.ready_o === 1'b1) acc = 1'b1;
                @(negedge clk);
                if (acc) break;
            end
            if (acc) acc_n++;
            if (k == 3) begin
                checks++;
                if (s.ready_o !== 1'b0 || s.done_o !== 1'b1 || s.err_o !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_after_4th: ready=%b done=%b err=%b required 0 1 1",
                             s.ready_o, s.done_o, s.err_o);
                end
            end
        end
        s.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (acc_n != 4 || sq.size() != 4) begin
            failures++;
            $display("FAIL ovf_accepts: accepts=%0d writes=%0d required 4 4", acc_n, sq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                enc = ref_encode(mk(4'd4, 5'd0, 5'(i + 1), 5'd0, 6'd0, 16'(i + 1), 26'd0, 1'b0));
                checks++;
                if (sq[i] !== {32'h40 + 32'(4 * i), enc[31:0]}) begin
                    failures++;
                    $display("FAIL ovf_word%0d: got %h required %h", i, sq[i], {32'h40 + 32'(4 * i), enc[31:0]});
                end
            end
        end
        checks++;
        if (s.count_o !== 3'd4 || s.err_o !== 1'b1 || s.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_status: count=%0d err=%b busy=%b required 4 1 0", s.count_o, s.err_o, s.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int n_before;
        clear_mon();
        start_sess(32'h500);
        send(mk(4'd4, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1, 26'd0, 1'b0));
        send(mk(4'd4, 5'd2, 5'd2, 5'd0, 6'd0, 16'h2, 26'd0, 1'b0));
        b.valid_i = 1'b0;
        @(negedge clk);
        n_before = wq.size();
        b.valid_i = 1'b1; b.op_sel_i = 4'd4; b.last_i = 1'b0; b.imm_i = 16'h3;
        checks++;
        if (b.ready_o !== 1'b1 || n_before != 2) begin
            failures++;
            $display("FAIL rstmid_pre: ready=%b writes=%0d required 1 2", b.ready_o, n_before);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b.ready_o, b.im_we_o, b.im_addr_o, b.im_data_o, b.busy_o, b.done_o, b.err_o, b.count_o} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: ready=%b we=%b addr=%h data=%h busy=%b count=%0d required all 0",
                     b.ready_o, b.im_we_o, b.im_addr_o, b.im_data_o, b.busy_o, b.count_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 2 || b.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_write: writes=%0d busy=%b required 2 0", wq.size(), b.busy_o);
        end
        clear_mon();
        start_sess(32'h600);
        send(mk(4'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1));
        b.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 1 || wq[0] !== {32'h600, 32'h20080005} || b.count_o !== 9'd1) begin
            failures++;
            $display("FAIL rstmid_resume: writes=%0d first=%h count=%0d required 1 %h 1",
                     wq.size(), (wq.size() > 0) ? wq[0] : 64'd0, {32'h600, 32'h20080005}, b.count_o);
        end
    endtask

    task automatic test_stall_random();
        logic [63:0]   exp[$];
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        logic [32:0]   enc;
        int            n;
        int            ecnt;
        bit            eerr;
        desc_t         d;
        for (int sess = 0; sess < 6; sess++) begin
            clear_mon();
            exp.delete();
            base = (sess == 0) ? 32'hFFFF_FFF8 : AW'($urandom);
            a    = base;
            ecnt = 0;
            eerr = 1'b0;
            n    = $urandom_range(3, 12);
            start_sess(base);
            for (int k = 0; k < n; k++) begin
                d = rand_desc(k == n - 1);
                enc = ref_encode(d);
                if (enc[32]) begin
                    exp.push_back({a, enc[31:0]});
                    a = a + 32'd4;
                    ecnt++;
                end else begin
                    eerr = 1'b1;
                end
                b.valid_i = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    b.start_i = ($urandom_range(0, 1) == 1);
                    b.base_i  = AW'($urandom);
                    @(negedge clk);
                    b.start_i = 1'b0;
                end
                send(d);
            end
            b.valid_i = 1'b0;
            repeat (4) @(negedge clk);
            checks++;
            if (wq.size() != exp.size()) begin
                failures++;
                $display("FAIL rnd%0d_writes: got %0d required %0d", sess, wq.size(), exp.size());
            end
            for (int i = 0; i < exp.size() && i < wq.size(); i++) begin
                checks++;
                if (wq[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL rnd%0d_word%0d: got %h required %h", sess, i, wq[i], exp[i]);
                end
            end
            checks++;
            if (b.count_o !== 9'(ecnt) || b.err_o !== eerr || dcyc.size() != 1) begin
                failures++;
                $display("FAIL rnd%0d_status: count=%0d err=%b dones=%0d required %0d %b 1",
                         sess, b.count_o, b.err_o, dcyc.size(), ecnt, eerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_invalid();
        test_overflow();
        test_reset_mid();
        test_stall_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
